// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Holds the 3-bit operation encodings used by the datapath core and
// the pipeline wrapper, plus a small helper to classify operations.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_NOTA = 3'b000;
  localparam op_t OP_NOTB = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_ADD  = 3'b110;
  localparam op_t OP_SUB  = 3'b111;

  // Only ADD and SUB produce meaningful carry/overflow.
  function automatic logic is_arith(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: logic ops, ADD and SUB with C/N/Z/V flags.
// Ports:
//   a, b    - operands (WIDTH bits)
//   op      - operation select (see alu_pkg)
//   result  - operation result, wraps modulo 2^WIDTH
//   c, n, z, v - carry (1 = no borrow on SUB), negative, zero, overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum    = '0;
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Two's complement subtract; carry out of the top bit means no borrow.
        sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = '0;
    endcase
    n = result[WIDTH-1];
    z = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU.
// Stage 1 registers the operands and op; stage 2 registers the result and
// flags computed by alu_core from stage 1. Full throughput with out_ready=1;
// holds up to two beats under backpressure.
// Ports:
//   clk, reset_n         - clock, synchronous active-low reset
//   in_valid, in_ready   - input handshake
//   a, b, op             - operands and operation select
//   out_valid, out_ready - output handshake
//   result, c, n, z, v   - registered result and flags
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_c_q, s2_n_q, s2_z_q, s2_v_q;

  logic [WIDTH-1:0] core_result;
  logic             core_c, core_n, core_z, core_v;

  logic s2_adv;
  logic s1_adv;

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv;
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_alu_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (core_result),
    .c      (core_c),
    .n      (core_n),
    .z      (core_z),
    .v      (core_v)
  );

  // Control and stage-2 data; stage-2 data is cleared so outputs read zero after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_c_q      <= 1'b0;
      s2_n_q      <= 1'b0;
      s2_z_q      <= 1'b0;
      s2_v_q      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_result_q <= core_result;
          s2_c_q      <= core_c;
          s2_n_q      <= core_n;
          s2_z_q      <= core_z;
          s2_v_q      <= core_v;
        end
      end
    end
  end

  // Stage-1 operands need no reset: they are only consumed when s1_valid_q is set.
  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_a_q  <= a;
      s1_b_q  <= b;
      s1_op_q <= op;
    end
  end

  always_comb begin
    out_valid = s2_valid_q;
    result    = s2_result_q;
    c         = s2_c_q;
    n         = s2_n_q;
    z         = s2_z_q;
    v         = s2_v_q;
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed flag cases, logic ops,
// back-to-back throughput, backpressure, mid-flight reset and random traffic
// against an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] op;
  logic       c, n, z, v;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];  // {c, n, z, v, result}

  always #5 clk = ~clk;

  alu_pipe #(
    .WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c         (c),
    .n         (n),
    .z         (z),
    .v         (v)
  );

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic logic [11:0] model(input logic [7:0] ia, input logic [7:0] ib,
                                        input logic [2:0] iop);
    int ua, ub, sa, sb, full, sres;
    logic [7:0] r;
    logic fc, fv;
    ua = int'(ia);
    ub = int'(ib);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    fc = 1'b0;
    fv = 1'b0;
    case (iop)
      3'd0: r = ~ia;
      3'd1: r = ~ib;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = ~(ia ^ ib);
      3'd6: begin
        full = ua + ub;
        r    = full[7:0];
        fc   = (full > 255);
        sres = sa + sb;
        fv   = (sres > 127) || (sres < -128);
      end
      default: begin
        full = ua - ub;
        r    = full[7:0];
        fc   = (ua >= ub);
        sres = sa - sb;
        fv   = (sres > 127) || (sres < -128);
      end
    endcase
    return {fc, r[7], (r == 8'd0), fv, r};
  endfunction

  // Drives one cycle of inputs and samples the DUT 1 time unit later (mid-low phase).
  task automatic drive_cycle(input logic rn, input logic iv, input logic [7:0] ia,
                             input logic [7:0] ib, input logic [2:0] iop, input logic ordy,
                             output logic acc, output logic ir, output logic ov,
                             output logic [11:0] obs);
    @(negedge clk);
    reset_n   = rn;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    #1;
    ir  = in_ready;
    acc = rn && iv && in_ready;
    ov  = out_valid;
    obs = {c, n, z, v, result};
  endtask

  task automatic test_reset();
    logic acc, ir, ov;
    logic [11:0] obs;
    repeat (3) drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc, ir, ov, obs);
    n_checks++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", ov);
    end
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_result_flags: got %h expected 000", obs);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
    n_checks++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", ir);
    end
  endtask

  task automatic test_arith();
    logic [7:0]  ta[4]  = '{8'hFF, 8'h7F, 8'h05, 8'h0A};
    logic [7:0]  tb[4]  = '{8'h01, 8'h01, 8'h07, 8'h0A};
    logic [2:0]  top[4] = '{3'd6, 3'd6, 3'd7, 3'd7};
    // {c, n, z, v, result}
    logic [11:0] texp[4] = '{12'hA00, 12'h580, 12'h4FE, 12'hA00};
    logic acc, ir, ov;
    logic [11:0] obs;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b1, ta[i], tb[i], top[i], 1'b1, acc, ir, ov, obs);
      n_checks++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_accept[%0d]: got %b expected 1", i, acc);
      end
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
      n_checks++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL arith_early_valid[%0d]: got %b expected 0", i, ov);
      end
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
      n_checks++;
      if (ov !== 1'b1 || obs !== texp[i]) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: got valid=%b cnzv_res=%h expected valid=1 cnzv_res=%h",
                 i, ov, obs, texp[i]);
      end
    end
  endtask

  task automatic test_logic();
    logic [7:0] tres[6] = '{8'h0F, 8'hC3, 8'h30, 8'hFC, 8'hCC, 8'h33};
    logic [7:0] r;
    logic [11:0] e;
    logic acc, ir, ov;
    logic [11:0] obs;
    for (int i = 0; i < 6; i++) begin
      r = tres[i];
      e = {1'b0, r[7], 1'b0, 1'b0, r};
      drive_cycle(1'b1, 1'b1, 8'hF0, 8'h3C, 3'(i), 1'b1, acc, ir, ov, obs);
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
      n_checks++;
      if (ov !== 1'b1 || obs !== e) begin
        n_fail++;
        $display("FAIL logic_op%0d: got valid=%b cnzv_res=%h expected valid=1 cnzv_res=%h",
                 i, ov, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ir, ov;
    logic [11:0] obs, e;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    int n_acc = 0, n_out = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom);
      drive_cycle(1'b1, (cyc < 8), ra, rb, rop, 1'b1, acc, ir, ov, obs);
      if (acc) begin
        exp_q.push_back(model(ra, rb, rop));
        n_acc++;
      end
      if (ov) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_out++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_output: got %h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL b2b_result: got %h expected %h", obs, e);
          end
        end
      end
    end
    n_checks++;
    if (n_acc != 8 || n_out != 8 || first != 2 || last != 9) begin
      n_fail++;
      $display("FAIL b2b_timing: got acc=%0d out=%0d first=%0d last=%0d expected 8 8 2 9",
               n_acc, n_out, first, last);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[4], bb[4];
    logic [2:0] bop[4];
    logic acc, ir, ov;
    logic [11:0] obs, e, held;
    int sent = 0, delivered = 0;
    bit have_held = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i]  = 8'($urandom);
      bb[i]  = 8'($urandom);
      bop[i] = 3'($urandom);
    end
    for (int cyc = 0; cyc < 5; cyc++) begin
      drive_cycle(1'b1, (sent < 4), ba[sent % 4], bb[sent % 4], bop[sent % 4], 1'b0,
                  acc, ir, ov, obs);
      if (cyc >= 2) begin
        n_checks++;
        if (ir !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready_cyc%0d: got %b expected 0", cyc, ir);
        end
      end
      if (ov) begin
        if (!have_held) begin
          held = obs;
          have_held = 1;
        end else begin
          n_checks++;
          if (obs !== held) begin
            n_fail++;
            $display("FAIL bp_hold_cyc%0d: got %h expected %h", cyc, obs, held);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(model(ba[sent], bb[sent], bop[sent]));
        sent++;
      end
    end
    n_checks++;
    if (sent != 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d expected 2", sent);
    end
    for (int cyc = 0; cyc < 30 && (sent < 4 || exp_q.size() != 0); cyc++) begin
      drive_cycle(1'b1, (sent < 4), ba[sent % 4], bb[sent % 4], bop[sent % 4], 1'b1,
                  acc, ir, ov, obs);
      if (cyc == 0) begin
        n_checks++;
        if (acc !== 1'b1 || ov !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_full_shift: got accept=%b valid=%b expected 1 1", acc, ov);
        end
      end
      if (ov) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra_output: got %h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          delivered++;
          if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_result: got %h expected %h", obs, e);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(model(ba[sent], bb[sent], bop[sent]));
        sent++;
      end
    end
    n_checks++;
    if (delivered != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_delivered: got %0d pending=%0d expected 4 pending=0",
               delivered, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic acc, ir, ov;
    logic [11:0] obs;
    int n_acc = 0, stale = 0;
    drive_cycle(1'b1, 1'b1, 8'h12, 8'h34, 3'd6, 1'b0, acc, ir, ov, obs);
    n_acc += int'(acc);
    drive_cycle(1'b1, 1'b1, 8'h56, 8'h78, 3'd7, 1'b0, acc, ir, ov, obs);
    n_acc += int'(acc);
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc, ir, ov, obs);
    n_checks++;
    if (n_acc != 2 || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_setup: got accepted=%0d valid=%b expected 2 1", n_acc, ov);
    end
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
    n_checks++;
    if (ov !== 1'b0 || obs !== 12'h000) begin
      n_fail++;
      $display("FAIL rst_mid_clear: got valid=%b cnzv_res=%h expected 0 000", ov, obs);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc, ir, ov, obs);
      if (ov) stale++;
    end
    n_checks++;
    if (stale != 0) begin
      n_fail++;
      $display("FAIL rst_mid_stale: got %0d outputs expected 0", stale);
    end
  endtask

  task automatic test_random();
    logic acc, ir, ov, iv, ordy;
    logic [11:0] obs, e, prev_obs;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    logic prev_stall = 1'b0;
    for (int cyc = 0; cyc < 310; cyc++) begin
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      rop  = 3'($urandom);
      iv   = (cyc < 300) && ($urandom_range(3) != 0);
      ordy = (cyc >= 300) || ($urandom_range(2) != 0);
      drive_cycle(1'b1, iv, ra, rb, rop, ordy, acc, ir, ov, obs);
      if (prev_stall) begin
        n_checks++;
        if (ov !== 1'b1 || obs !== prev_obs) begin
          n_fail++;
          $display("FAIL rnd_hold: got valid=%b %h expected 1 %h", ov, obs, prev_obs);
        end
      end
      if (ov && ordy) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra_output: got %h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          if (obs !== e) begin
            n_fail++;
            $display("FAIL rnd_result: got %h expected %h", obs, e);
          end
        end
      end
      if (acc) exp_q.push_back(model(ra, rb, rop));
      prev_stall = ov && !ordy;
      prev_obs   = obs;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b0;
    test_reset();
    test_arith();
    test_logic();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
